// File: rtl/controle_registrador_if.sv
// Command/handshake bundle between a requester and the shift-register sequencer,
// plus the mode/data lines the sequencer drives into the 16-bit register.
interface controle_registrador_if #(
  parameter int LARG    = 16,
  parameter int PASSO_W = 5
);
  logic               start;
  logic [1:0]         cmd;
  logic [LARG-1:0]    dado;
  logic               serial_in;
  logic [PASSO_W-1:0] passos;
  logic               busy;
  logic               done;
  logic               ch1;
  logic               ch0;
  logic               d;
  logic [LARG-1:0]    bits;

  modport master (
    output start, cmd, dado, serial_in, passos,
    input  busy, done, ch1, ch0, d, bits
  );

  modport slave (
    input  start, cmd, dado, serial_in, passos,
    output busy, done, ch1, ch0, d, bits
  );
endinterface

// File: rtl/controle_registrador.sv
// Sequencer for the 16-bit universal shift register: runs one load/shift/rotate
// command at a time and drives the register's mode, serial and parallel inputs.
module controle_registrador #(
  parameter int LARG    = 16,
  parameter int PASSO_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  controle_registrador_if.slave  bus
);

  localparam logic [1:0]         CMD_CARGA  = 2'b00;
  localparam logic [1:0]         CMD_DESLOC = 2'b01;
  localparam logic [1:0]         CMD_CROT   = 2'b11;
  localparam logic [PASSO_W-1:0] MAX_PASSOS = PASSO_W'(LARG);

  typedef enum logic [1:0] {OCIOSO, CARGA, DESLOCA, FIM} estado_t;

  estado_t            estado, estado_nxt;
  logic [1:0]         cmd_q, cmd_nxt;
  logic               sin_q, sin_nxt;
  logic [LARG-1:0]    dado_q, dado_nxt;
  logic [PASSO_W-1:0] cnt_q, cnt_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic               ch1_q, ch1_nxt;
  logic               ch0_q, ch0_nxt;
  logic               d_q, d_nxt;

  function automatic logic [PASSO_W-1:0] satura(input logic [PASSO_W-1:0] p);
    return (p > MAX_PASSOS) ? MAX_PASSOS : p;
  endfunction

  always_comb begin
    estado_nxt = estado;
    cmd_nxt    = cmd_q;
    sin_nxt    = sin_q;
    dado_nxt   = dado_q;
    cnt_nxt    = cnt_q;
    case (estado)
      OCIOSO: begin
        if (bus.start) begin
          cmd_nxt  = bus.cmd;
          sin_nxt  = bus.serial_in;
          dado_nxt = bus.dado;
          cnt_nxt  = satura(bus.passos);
          if (bus.cmd == CMD_CARGA || bus.cmd == CMD_CROT)
            estado_nxt = CARGA;
          else if (satura(bus.passos) == '0)
            estado_nxt = FIM;
          else
            estado_nxt = DESLOCA;
        end
      end
      CARGA: begin
        if (cmd_q == CMD_CARGA || cnt_q == '0)
          estado_nxt = FIM;
        else
          estado_nxt = DESLOCA;
      end
      DESLOCA: begin
        // Counter holds the steps still to run including this one.
        if (cnt_q != '0)
          cnt_nxt = cnt_q - PASSO_W'(1);
        if (cnt_q <= PASSO_W'(1))
          estado_nxt = FIM;
      end
      FIM:     estado_nxt = OCIOSO;
      default: estado_nxt = OCIOSO;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register on the same edge.
  always_comb begin
    busy_nxt = (estado_nxt != OCIOSO);
    done_nxt = (estado_nxt == FIM);
    ch1_nxt  = 1'b0;
    ch0_nxt  = 1'b0;
    d_nxt    = 1'b0;
    case (estado_nxt)
      CARGA: begin
        ch1_nxt = 1'b1;
      end
      DESLOCA: begin
        if (cmd_nxt == CMD_DESLOC) begin
          ch0_nxt = 1'b1;
          d_nxt   = sin_nxt;
        end else begin
          ch1_nxt = 1'b1;
          ch0_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
      cmd_q  <= '0;
      sin_q  <= 1'b0;
      dado_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ch1_q  <= 1'b0;
      ch0_q  <= 1'b0;
      d_q    <= 1'b0;
    end else begin
      estado <= estado_nxt;
      cmd_q  <= cmd_nxt;
      sin_q  <= sin_nxt;
      dado_q <= dado_nxt;
      cnt_q  <= cnt_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      ch1_q  <= ch1_nxt;
      ch0_q  <= ch0_nxt;
      d_q    <= d_nxt;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ch1  = ch1_q;
  assign bus.ch0  = ch0_q;
  assign bus.d    = d_q;
  assign bus.bits = dado_q;

endmodule

// File: tb/tb_controle_registrador.sv
// Bench for controle_registrador: drives commands into the sequencer, models the
// downstream 16-bit universal shift register and checks its contents on done.
module tb_controle_registrador;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controle_registrador_if bus();
  controle_registrador dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Downstream register: 00 hold, 01 shift in d, 10 load, 11 rotate.
  logic [15:0] reg_q = '0;
  always_ff @(posedge clk) begin
    case ({bus.ch1, bus.ch0})
      2'b01:   reg_q <= {reg_q[14:0], bus.d};
      2'b10:   reg_q <= bus.bits;
      2'b11:   reg_q <= {reg_q[14:0], reg_q[15]};
      default: ;
    endcase
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  // Issues one command and records what the DUT did; inj >= 0 pulses a stray
  // load request (dado FFFF) at that observed cycle.
  task automatic run_cmd(input logic [1:0] c, input logic [15:0] v, input logic s,
                         input logic [4:0] p, input int inj,
                         output int n_busy, output int n_load, output int n_shift,
                         output int n_rot, output int n_done, output logic [15:0] reg_done,
                         output logic d_ok, output logic bits_ok);
    int  post;
    logic seen;
    n_busy = 0; n_load = 0; n_shift = 0; n_rot = 0; n_done = 0;
    reg_done = 16'hxxxx; d_ok = 1'b1; bits_ok = 1'b1; seen = 1'b0; post = 0;
    @(negedge clk);
    bus.cmd = c; bus.dado = v; bus.serial_in = s; bus.passos = p; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 60 && post < 3; i++) begin
      if (i == inj) begin
        bus.start = 1'b1; bus.cmd = 2'b00; bus.dado = 16'hFFFF;
      end else if (i == inj + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy === 1'b1) n_busy++;
      case ({bus.ch1, bus.ch0})
        2'b01:   n_shift++;
        2'b10:   n_load++;
        2'b11:   n_rot++;
        default: ;
      endcase
      if ({bus.ch1, bus.ch0} == 2'b01) d_ok = d_ok & (bus.d === s);
      else                             d_ok = d_ok & (bus.d === 1'b0);
      if (bus.bits !== v) bits_ok = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (!seen) reg_done = reg_q;
        seen = 1'b1;
      end
      if (seen) post++;
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if ({bus.ch1, bus.ch0} !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", {bus.ch1, bus.ch0}); end
    n_checks++; if (bus.d !== 1'b0) begin n_fail++; $display("FAIL reset_d: got %b want 0", bus.d); end
    n_checks++; if (bus.bits !== 16'h0000) begin n_fail++; $display("FAIL reset_bits: got %h want 0000", bus.bits); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_load();
    int nb, nl, ns, nr, nd; logic [15:0] rd, e; logic dk, bk;
    exp_q.push_back(16'hA5C3);
    run_cmd(2'b00, 16'hA5C3, 1'b0, 5'd0, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL load_reg: got %h want %h", rd, e); end
    n_checks++; if (nl !== 1) begin n_fail++; $display("FAIL load_mode10_cycles: got %0d want 1", nl); end
    n_checks++; if (nb !== 2) begin n_fail++; $display("FAIL load_busy_cycles: got %0d want 2", nb); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL load_done_cycles: got %0d want 1", nd); end
    n_checks++; if (ns + nr !== 0) begin n_fail++; $display("FAIL load_shift_cycles: got %0d want 0", ns + nr); end
  endtask

  task automatic test_load_rotate();
    int nb, nl, ns, nr, nd; logic [15:0] rd, e; logic dk, bk;
    exp_q.push_back(16'h00F0);
    run_cmd(2'b11, 16'h000F, 1'b0, 5'd4, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL lrot_reg: got %h want %h", rd, e); end
    n_checks++; if (nl !== 1 || nr !== 4) begin n_fail++; $display("FAIL lrot_modes: got load=%0d rot=%0d want 1/4", nl, nr); end
    n_checks++; if (nb !== 6) begin n_fail++; $display("FAIL lrot_busy_cycles: got %0d want 6", nb); end
    n_checks++; if (dk !== 1'b1) begin n_fail++; $display("FAIL lrot_d: got d_ok=%b want 1", dk); end
    exp_q.push_back(16'h8001);
    run_cmd(2'b00, 16'h8001, 1'b0, 5'd0, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL lrot_reload: got %h want %h", rd, e); end
    exp_q.push_back(16'h0003);
    run_cmd(2'b10, 16'h8001, 1'b0, 5'd1, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL rot1_reg: got %h want %h", rd, e); end
    n_checks++; if (nr !== 1 || nl !== 0 || nb !== 2) begin n_fail++; $display("FAIL rot1_cycles: got rot=%0d load=%0d busy=%0d want 1/0/2", nr, nl, nb); end
  endtask

  task automatic test_shift();
    int nb, nl, ns, nr, nd; logic [15:0] rd, e; logic dk, bk;
    exp_q.push_back(16'h0000);
    run_cmd(2'b00, 16'h0000, 1'b0, 5'd0, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL shift_clear: got %h want %h", rd, e); end
    exp_q.push_back(16'h0007);
    run_cmd(2'b01, 16'h0000, 1'b1, 5'd3, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL shift_reg: got %h want %h", rd, e); end
    n_checks++; if (ns !== 3 || nr !== 0 || nl !== 0) begin n_fail++; $display("FAIL shift_modes: got shift=%0d rot=%0d load=%0d want 3/0/0", ns, nr, nl); end
    n_checks++; if (dk !== 1'b1) begin n_fail++; $display("FAIL shift_d: got d_ok=%b want 1", dk); end
    n_checks++; if (nb !== 4) begin n_fail++; $display("FAIL shift_busy_cycles: got %0d want 4", nb); end
    exp_q.push_back(16'h0007);
    run_cmd(2'b01, 16'h0000, 1'b1, 5'd0, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL shift0_reg: got %h want %h", rd, e); end
    n_checks++; if (nb !== 1 || ns !== 0 || nd !== 1) begin n_fail++; $display("FAIL shift0_cycles: got busy=%0d shift=%0d done=%0d want 1/0/1", nb, ns, nd); end
    exp_q.push_back(16'h0007);
    run_cmd(2'b10, 16'h0000, 1'b0, 5'd0, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e || nb !== 1 || nr !== 0) begin n_fail++; $display("FAIL rot0: got reg=%h busy=%0d rot=%0d want %h/1/0", rd, nb, nr, e); end
  endtask

  task automatic test_saturation();
    int nb, nl, ns, nr, nd; logic [15:0] rd, e; logic dk, bk;
    exp_q.push_back(16'h1234);
    run_cmd(2'b11, 16'h1234, 1'b0, 5'd20, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL sat_reg: got %h want %h", rd, e); end
    n_checks++; if (nr !== 16) begin n_fail++; $display("FAIL sat_rot_cycles: got %0d want 16", nr); end
    n_checks++; if (nb !== 18) begin n_fail++; $display("FAIL sat_busy_cycles: got %0d want 18", nb); end
    exp_q.push_back(16'h1234);
    run_cmd(2'b10, 16'h0000, 1'b0, 5'd31, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e || nr !== 16 || nb !== 17) begin n_fail++; $display("FAIL sat31: got reg=%h rot=%0d busy=%0d want %h/16/17", rd, nr, nb, e); end
  endtask

  task automatic test_handshake();
    int nb, nl, ns, nr, nd; logic [15:0] rd, e; logic dk, bk;
    exp_q.push_back(16'h0001);
    run_cmd(2'b00, 16'h0001, 1'b0, 5'd0, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL hs_preload: got %h want %h", rd, e); end
    exp_q.push_back(16'h0400);
    run_cmd(2'b10, 16'h5A5A, 1'b0, 5'd10, 3, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL hs_reg: got %h want %h", rd, e); end
    n_checks++; if (nl !== 0) begin n_fail++; $display("FAIL hs_extra_load: got %0d want 0", nl); end
    n_checks++; if (bk !== 1'b1) begin n_fail++; $display("FAIL hs_bits: got bits_ok=%b want 1", bk); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL hs_done_cycles: got %0d want 1", nd); end
    n_checks++; if (nb !== 11) begin n_fail++; $display("FAIL hs_busy_cycles: got %0d want 11", nb); end
  endtask

  task automatic test_reset_mid();
    int nb, nl, ns, nr, nd; logic [15:0] rd, e; logic dk, bk;
    @(negedge clk);
    bus.cmd = 2'b10; bus.dado = 16'h3C3C; bus.serial_in = 1'b0; bus.passos = 5'd10; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if ({bus.ch1, bus.ch0} !== 2'b11 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_active: got mode=%b busy=%b want 11/1", {bus.ch1, bus.ch0}, bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.ch1, bus.ch0} !== 2'b00) begin n_fail++; $display("FAIL rstmid_mode: got %b want 00", {bus.ch1, bus.ch0}); end
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_done: got %b/%b want 0/0", bus.busy, bus.done); end
    n_checks++; if (bus.bits !== 16'h0000 || bus.d !== 1'b0) begin n_fail++; $display("FAIL rstmid_bits_d: got %h/%b want 0000/0", bus.bits, bus.d); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    exp_q.push_back(16'hBEEF);
    run_cmd(2'b00, 16'hBEEF, 1'b0, 5'd0, -1, nb, nl, ns, nr, nd, rd, dk, bk);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e || nl !== 1 || nb !== 2 || nd !== 1) begin n_fail++; $display("FAIL rstmid_reload: got reg=%h load=%0d busy=%0d done=%0d want %h/1/2/1", rd, nl, nb, nd, e); end
  endtask

  initial begin
    bus.start = 1'b0; bus.cmd = 2'b00; bus.dado = 16'h0000; bus.serial_in = 1'b0; bus.passos = 5'd0;
    test_reset();
    test_load();
    test_load_rotate();
    test_shift();
    test_saturation();
    test_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
